// File: rtl/stat_frame_pkg.sv
// Shared constants and types for the cache-statistics ASCII stream:
// frame tags, hex digit ranges, decoder FSM states and cache level indices.
package stat_frame_pkg;

    localparam logic [7:0] TAG_L1I = 8'h61;
    localparam logic [7:0] TAG_L1D = 8'h62;
    localparam logic [7:0] TAG_L2  = 8'h63;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_F = 8'h46;

    localparam int NUM_LEVELS = 3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DIGITS = 2'd1,
        COMMIT = 2'd2
    } dec_state_e;

    // Level numbering is shared with the counter/encoder side of the link.
    typedef enum logic [1:0] {
        LVL_L1I = 2'd0,
        LVL_L1D = 2'd1,
        LVL_L2  = 2'd2
    } cache_level_e;

    function automatic logic is_tag(input logic [7:0] b);
        return (b == TAG_L1I) || (b == TAG_L1D) || (b == TAG_L2);
    endfunction

    function automatic cache_level_e tag_level(input logic [7:0] b);
        case (b)
            TAG_L1D: return LVL_L1D;
            TAG_L2:  return LVL_L2;
            default: return LVL_L1I;
        endcase
    endfunction

endpackage

// File: rtl/ascii_hex_nibble.sv
// Combinational ASCII to hex nibble decoder. Accepts '0'-'9' and uppercase
// 'A'-'F' only; lowercase letters are reported invalid.
module ascii_hex_nibble
    import stat_frame_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       valid_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        valid_o  = 1'b0;
        nibble_o = 4'h0;
        if (byte_i >= ASCII_0 && byte_i <= ASCII_9) begin
            valid_o  = 1'b1;
            nibble_o = byte_i[3:0];
        end else if (byte_i >= ASCII_A && byte_i <= ASCII_F) begin
            valid_o  = 1'b1;
            nibble_o = byte_i[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/stat_frame_decoder.sv
// Parses "tag + miss digits + access digits" frames from a byte FIFO and
// publishes per-level count pairs atomically. Optional STAT_DEC_ERRCNT_EN adds err_cnt.
module stat_frame_decoder
    import stat_frame_pkg::*;
#(
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_dout,
    output logic             fifo_rd_en,
    output logic [CNT_W-1:0] l1i_miss,
    output logic [CNT_W-1:0] l1i_acc,
    output logic [CNT_W-1:0] l1d_miss,
    output logic [CNT_W-1:0] l1d_acc,
    output logic [CNT_W-1:0] l2_miss,
    output logic [CNT_W-1:0] l2_acc,
    output logic             upd_l1i,
    output logic             upd_l1d,
    output logic             upd_l2,
    output logic             frame_err
`ifdef STAT_DEC_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int DIG   = CNT_W / 4;
    localparam int NDIG  = 2 * DIG;
    localparam int IDX_W = (NDIG < 2) ? 1 : $clog2(NDIG);
    localparam int TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic             rd_en_q;
    logic             byte_vld_q;
    dec_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    cache_level_e     lvl_q, lvl_d;
    logic [CNT_W-1:0] miss_sh_q, miss_sh_d;
    logic [CNT_W-1:0] acc_sh_q, acc_sh_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             err_q, err_d;
    logic             commit_d;

    logic [CNT_W-1:0]      miss_q [NUM_LEVELS];
    logic [CNT_W-1:0]      acc_q  [NUM_LEVELS];
    logic [NUM_LEVELS-1:0] upd_q;

    logic       hex_vld;
    logic [3:0] hex_nib;

    ascii_hex_nibble u_hex (
        .byte_i   (fifo_dout),
        .valid_o  (hex_vld),
        .nibble_o (hex_nib)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lvl_d     = lvl_q;
        miss_sh_d = miss_sh_q;
        acc_sh_d  = acc_sh_q;
        to_cnt_d  = '0;
        err_d     = 1'b0;
        commit_d  = 1'b0;
        case (state_q)
            HUNT: begin
                if (byte_vld_q && is_tag(fifo_dout)) begin
                    lvl_d     = tag_level(fifo_dout);
                    miss_sh_d = '0;
                    acc_sh_d  = '0;
                    idx_d     = '0;
                    state_d   = DIGITS;
                end
            end
            DIGITS: begin
                if (byte_vld_q) begin
                    if (hex_vld) begin
                        if (idx_q < IDX_W'(DIG)) begin
                            miss_sh_d = (miss_sh_q << 4) | CNT_W'(hex_nib);
                        end else begin
                            acc_sh_d = (acc_sh_q << 4) | CNT_W'(hex_nib);
                        end
                        if (idx_q == IDX_W'(NDIG - 1)) begin
                            idx_d    = '0;
                            commit_d = 1'b1;
                            state_d  = COMMIT;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (is_tag(fifo_dout)) begin
                            lvl_d     = tag_level(fifo_dout);
                            miss_sh_d = '0;
                            acc_sh_d  = '0;
                            idx_d     = '0;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    // A byte arriving in the expiry cycle wins: this branch is skipped.
                    if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            COMMIT:  state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_en_q    <= 1'b0;
            byte_vld_q <= 1'b0;
            state_q    <= HUNT;
            idx_q      <= '0;
            lvl_q      <= LVL_L1I;
            miss_sh_q  <= '0;
            acc_sh_q   <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            // Registered pop: a request is never issued while a byte is in flight.
            rd_en_q    <= !fifo_empty && !rd_en_q;
            byte_vld_q <= rd_en_q;
            state_q    <= state_d;
            idx_q      <= idx_d;
            lvl_q      <= lvl_d;
            miss_sh_q  <= miss_sh_d;
            acc_sh_q   <= acc_sh_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
        end
    end

    // The commit is registered on the edge entering COMMIT, so the new pair
    // and its strobe are both visible during the COMMIT cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (!rstn) begin
                miss_q[i] <= '0;
                acc_q[i]  <= '0;
                upd_q[i]  <= 1'b0;
            end else begin
                upd_q[i] <= commit_d && (int'(lvl_q) == i);
                if (commit_d && (int'(lvl_q) == i)) begin
                    miss_q[i] <= miss_sh_d;
                    acc_q[i]  <= acc_sh_d;
                end
            end
        end
    end

`ifdef STAT_DEC_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt_q <= 8'd0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign fifo_rd_en = rd_en_q;
    assign frame_err  = err_q;
    assign l1i_miss   = miss_q[0];
    assign l1i_acc    = acc_q[0];
    assign l1d_miss   = miss_q[1];
    assign l1d_acc    = acc_q[1];
    assign l2_miss    = miss_q[2];
    assign l2_acc     = acc_q[2];
    assign upd_l1i    = upd_q[0];
    assign upd_l1d    = upd_q[1];
    assign upd_l2     = upd_q[2];

endmodule

// File: tb/tb_stat_frame_decoder.sv
// Self-checking bench for stat_frame_decoder: directed scenarios plus random
// frames, compared each cycle against a frame-level reference model.
module tb_stat_frame_decoder;

    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 20;
    localparam int DIG     = CNT_W / 4;

    logic             clk        = 1'b0;
    logic             rstn       = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [7:0]       fifo_dout  = 8'h00;
    logic             fifo_rd_en;
    logic [CNT_W-1:0] l1i_miss, l1i_acc, l1d_miss, l1d_acc, l2_miss, l2_acc;
    logic             upd_l1i, upd_l1d, upd_l2, frame_err;
`ifdef STAT_DEC_ERRCNT_EN
    logic [7:0]       err_cnt;
`endif

    always #5 clk = ~clk;

    stat_frame_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .l1i_miss   (l1i_miss),
        .l1i_acc    (l1i_acc),
        .l1d_miss   (l1d_miss),
        .l1d_acc    (l1d_acc),
        .l2_miss    (l2_miss),
        .l2_acc     (l2_acc),
        .upd_l1i    (upd_l1i),
        .upd_l1d    (upd_l1d),
        .upd_l2     (upd_l2),
        .frame_err  (frame_err)
`ifdef STAT_DEC_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] fifo_q[$];

    // Reference model: frames are assembled as whole numbers from the bytes
    // the bench hands out, one processed byte per clock edge.
    longint     m_miss[3];
    longint     m_acc[3];
    bit         m_in_frame;
    int         m_lvl, m_ndig, m_idle, m_errs;
    longint     m_val;
    bit         m_pend;
    logic [7:0] m_pend_byte;
    logic [2:0] exp_upd;
    bit         exp_err;
    int         upd_seen[3];
    int         err_seen;
    int         step_no, last_sample_step, last_err_step;
    string      hexchars = "0123456789ABCDEF";
    string      badchars = "Gxbd@c";
    string      junk     = "xyz9F@";

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int hex_val(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
        return -1;
    endfunction

    function automatic bit tag_byte(input logic [7:0] b);
        return (b == 8'h61) || (b == 8'h62) || (b == 8'h63);
    endfunction

    task automatic model_start(input logic [7:0] b);
        m_in_frame = 1'b1;
        m_lvl      = int'(b) - 97;
        m_ndig     = 0;
        m_val      = 0;
    endtask

    task automatic model_parse(input logic [7:0] b);
        int nv;
        longint base;
        nv   = hex_val(b);
        base = 64'd1 << (4 * DIG);
        m_idle = 0;
        last_sample_step = step_no;
        if (!m_in_frame) begin
            if (tag_byte(b)) model_start(b);
        end else if (nv >= 0) begin
            m_val  = m_val * 16 + nv;
            m_ndig = m_ndig + 1;
            if (m_ndig == 2 * DIG) begin
                m_miss[m_lvl] = m_val / base;
                m_acc[m_lvl]  = m_val % base;
                exp_upd[m_lvl] = 1'b1;
                m_in_frame = 1'b0;
            end
        end else begin
            exp_err = 1'b1;
            if (tag_byte(b)) model_start(b);
            else m_in_frame = 1'b0;
        end
    endtask

    task automatic model_edge(input bit rst_edge, input bit pop);
        exp_upd = 3'b000;
        exp_err = 1'b0;
        if (rst_edge) begin
            for (int i = 0; i < 3; i++) begin
                m_miss[i] = 0;
                m_acc[i]  = 0;
            end
            m_in_frame = 1'b0;
            m_idle     = 0;
            m_errs     = 0;
            m_pend     = 1'b0;
            return;
        end
        if (m_pend) begin
            model_parse(m_pend_byte);
        end else if (m_in_frame && TIMEOUT > 0) begin
            m_idle = m_idle + 1;
            if (m_idle == TIMEOUT) begin
                exp_err    = 1'b1;
                m_in_frame = 1'b0;
                m_idle     = 0;
            end
        end
        if (exp_err && m_errs < 255) m_errs = m_errs + 1;
        m_pend      = pop;
        m_pend_byte = fifo_dout;
    endtask

    task automatic step();
        bit pop, rst_edge;
        logic [2:0] upd_obs;
        pop      = (fifo_rd_en === 1'b1);
        rst_edge = !rstn;
        @(posedge clk);
        #1;
        step_no++;
        if (pop && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        model_edge(rst_edge, pop);
        upd_obs = {upd_l2, upd_l1d, upd_l1i};
        check("upd", upd_obs, exp_upd);
        check("frame_err", frame_err, exp_err);
        check("l1i_miss", l1i_miss, m_miss[0]);
        check("l1i_acc", l1i_acc, m_acc[0]);
        check("l1d_miss", l1d_miss, m_miss[1]);
        check("l1d_acc", l1d_acc, m_acc[1]);
        check("l2_miss", l2_miss, m_miss[2]);
        check("l2_acc", l2_acc, m_acc[2]);
        check("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
        check("rd_en_back_to_back", fifo_rd_en & pop, 0);
        if (rst_edge) check("rd_en_in_reset", fifo_rd_en, 0);
`ifdef STAT_DEC_ERRCNT_EN
        check("err_cnt", err_cnt, m_errs);
`endif
        for (int i = 0; i < 3; i++) if (upd_obs[i] === 1'b1) upd_seen[i]++;
        if (frame_err === 1'b1) begin
            err_seen++;
            last_err_step = step_no;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push_byte(s[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fifo_q.size() > 0 || m_pend || m_in_frame) && n < 2000) begin
            step();
            n++;
        end
        check("drain_bound", n < 2000, 1);
        repeat (2) step();
    endtask

    task automatic consume();
        int n;
        n = 0;
        while ((fifo_q.size() > 0 || m_pend) && n < 200) begin
            step();
            n++;
        end
        check("consume_bound", n < 200, 1);
    endtask

    initial begin
        int e0, u0;
        repeat (3) step();
        check("rst_l1i", {l1i_miss, l1i_acc}, 0);
        check("rst_l1d", {l1d_miss, l1d_acc}, 0);
        check("rst_l2", {l2_miss, l2_acc}, 0);
        check("rst_ctrl", {fifo_rd_en, frame_err, upd_l1i, upd_l1d, upd_l2}, 0);
        rstn = 1'b1;

        push_str("a00A1F3");
        drain();
        check("single_l1i_miss", l1i_miss, 12'h00A);
        check("single_l1i_acc", l1i_acc, 12'h1F3);
        check("single_others", {l1d_miss, l1d_acc, l2_miss, l2_acc}, 0);
        check("single_upd_cnt", upd_seen[0], 1);

        push_str("a123456bABCDEFc000FFF");
        drain();
        check("burst_l1i", {l1i_miss, l1i_acc}, 24'h123456);
        check("burst_l1d", {l1d_miss, l1d_acc}, 24'hABCDEF);
        check("burst_l2", {l2_miss, l2_acc}, 24'h000FFF);
        check("burst_upd_cnt", {upd_seen[0][7:0], upd_seen[1][7:0], upd_seen[2][7:0]}, 24'h020101);

        e0 = err_seen;
        u0 = upd_seen[0];
        push_str("a12b111222");
        drain();
        check("resync_err_cnt", err_seen - e0, 1);
        check("resync_no_l1i", upd_seen[0] - u0, 0);
        check("resync_l1d", {l1d_miss, l1d_acc}, 24'h111222);

        e0 = err_seen;
        push_str("xxa1G3456a000001");
        drain();
        check("baddig_err_cnt", err_seen - e0, 1);
        check("baddig_l1i", {l1i_miss, l1i_acc}, 24'h000001);

        e0 = err_seen;
        push_str("a12");
        consume();
        repeat (25) step();
        check("timeout_err_cnt", err_seen - e0, 1);
        check("timeout_latency", last_err_step - last_sample_step, TIMEOUT);
        check("timeout_unchanged", {l1i_miss, l1i_acc, l2_miss, l2_acc}, 48'h000001_000FFF);
        push_str("c00100A");
        drain();
        check("after_timeout_l2", {l2_miss, l2_acc}, 24'h00100A);

        push_str("b12");
        consume();
        repeat (2) step();
        rstn = 1'b0;
        repeat (2) step();
        check("midrst_outputs", {l1i_miss, l1i_acc, l1d_miss, l1d_acc, l2_miss, l2_acc}, 0);
        check("midrst_rd_en", fifo_rd_en, 0);
        rstn = 1'b1;
        push_str("b00C00D");
        drain();
        check("midrst_recover", {l1d_miss, l1d_acc}, 24'h00C00D);

        for (int f = 0; f < 60; f++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                push_byte(8'h61 + 8'($urandom_range(0, 2)));
                for (int d = 0; d < 2 * DIG; d++) push_byte(hexchars[$urandom_range(0, 15)]);
            end else if (kind == 6) begin
                push_byte(8'h61 + 8'($urandom_range(0, 2)));
                for (int d = 0; d < $urandom_range(0, 4); d++) push_byte(hexchars[$urandom_range(0, 15)]);
                push_byte(badchars[$urandom_range(0, 5)]);
            end else if (kind == 7) begin
                push_byte(junk[$urandom_range(0, 5)]);
            end else if (kind == 8) begin
                push_str("b4");
                push_byte(hexchars[$urandom_range(0, 15)]);
                drain();
            end else begin
                push_str("a1e2345");
            end
            if ($urandom_range(0, 1) == 1) drain();
            else repeat ($urandom_range(0, 3)) step();
        end
        drain();

`ifdef STAT_DEC_ERRCNT_EN
        for (int k = 0; k < 300; k++) begin
            push_str("ax");
            if (k % 50 == 49) drain();
        end
        drain();
        check("err_cnt_saturate", err_cnt, 8'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
